spram_arbiter: RTL
==================

SPRAM_ARBITER -- requirements
Module: spram_arbiter

Interface
REQ-001 Parameters SHALL be: REG_WIDTH, 64, data width; REG_DEPTH, 64, RAM depth; ADDR_W, $clog2(REG_DEPTH), address width (derived, not overridable).
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 p0_valid, p1_valid  input  1  requester has an access pending.
REQ-005 p0_ready, p1_ready  output  1  request accepted this cycle; handshake = valid & ready.
REQ-006 p0_we, p1_we  input  1  1 = write, 0 = read.
REQ-007 p0_addr, p1_addr  input  ADDR_W  word address.
REQ-008 p0_wdata, p1_wdata  input  REG_WIDTH  write data.
REQ-009 p0_resp, p1_resp  output  1  one-cycle completion pulse.
REQ-010 p0_rdata, p1_rdata  output  REG_WIDTH  read data, valid only with the matching resp pulse.
REQ-011 ram_cs_n, ram_we, ram_addr, ram_din  output  1/1/ADDR_W/REG_WIDTH  single-port RAM command.
REQ-012 ram_dout  input  REG_WIDTH  RAM registered read data, valid one cycle after the RAM command.

Function
REQ-013 The FSM SHALL have the states IDLE, ISSUE and RESP, with transitions IDLE->ISSUE on any handshake, ISSUE->RESP unconditionally, and RESP->IDLE unconditionally.
REQ-014 In IDLE, exactly one ready SHALL assert combinationally: the winner among the asserted valids. No ready SHALL assert when neither valid is high or when the state is not IDLE.
REQ-015 On a handshake, the winner's id, we, addr and wdata SHALL be captured into registers, and requester inputs SHALL be ignored until the FSM returns to IDLE.
REQ-016 In ISSUE, the block SHALL drive ram_cs_n=0, ram_we=captured we, ram_addr=captured addr and ram_din=captured wdata for exactly one cycle. Outside ISSUE, ram_cs_n=1 and ram_we=0.
REQ-017 In RESP, the block SHALL assert resp for the captured id only. Its rdata SHALL be ram_dout for a read and all zeros for a write. The non-granted port's rdata SHALL be all zeros.
REQ-018 Latency SHALL be exactly: handshake in cycle T, RAM command in T+1, resp in T+2, earliest next handshake in T+3.
REQ-019 Arbitration SHALL be round-robin by default. A 1-bit pointer names the preferred port, and after each grant the pointer SHALL point to the other port.
REQ-020 If both valids rise while the FSM is busy, both SHALL be held, and the pointer SHALL decide at the next IDLE.
REQ-021 A single requester SHALL be granted back-to-back every 3 cycles without waiting on the pointer.
REQ-022 Address and data SHALL pass through unmodified, with no range checking; ADDR_W bits are taken as-is.

Reset
REQ-023 While rst_n=0, the FSM SHALL be IDLE, the pointer SHALL be 0, ready and resp SHALL be 0, ram_cs_n SHALL be 1, ram_we SHALL be 0, and ram_addr, ram_din, rdata and the capture registers SHALL be 0.
REQ-024 Reset asserted in ISSUE or RESP SHALL abort the access immediately, with no resp pulse; the RAM content outcome of an aborted write is undefined.
REQ-025 The first grant after reset release SHALL favour port 0.

Configuration
REQ-026 With macro SPRAM_ARB_FIXED_PRIO_EN defined, port 0 SHALL always win simultaneous requests and the pointer SHALL be removed. When the macro is undefined, round-robin per REQ-019 SHALL apply.

Structure
REQ-027 A shared package spram_arb_pkg SHALL hold the FSM state encoding (IDLE=2'd0, ISSUE=2'd1, RESP=2'd2), the port count constant (2) and the port-id constants (P0=1'b0, P1=1'b1).
REQ-028 One sub-module SHALL exist: rr_arb2, a 2-input grant generator with a pointer input, which becomes a fixed-priority selector under SPRAM_ARB_FIXED_PRIO_EN. The RAM itself SHALL stay external.

Verification
REQ-029 With p0 alone writing addr=5, wdata=64'hDEAD_BEEF, then reading addr=5: ram_cs_n=0/ram_we=1 at T+1, p0_resp at T+2, and the read returns p0_rdata=64'hDEAD_BEEF at its T+2.
REQ-030 With p0 and p1 reading simultaneously after reset, both held high: grants alternate p0, p1, p0 at cycles 0, 3, 6, and each resp goes only to its own port.
REQ-031 With SPRAM_ARB_FIXED_PRIO_EN defined and both valids held high: p0 is granted every 3 cycles and p1_ready stays 0.
REQ-032 With rst_n pulled low in ISSUE of a p1 read: no p1_resp appears, all outputs are at reset values within the same cycle, and after release p0 wins a tie.
REQ-033 With p1 issuing a write to addr=63 and writing 64'h1 while p0_valid rises in RESP: p0_ready stays 0 until IDLE, then p0 is granted.

Source files
------------

// File: rtl/spram_arb_pkg.sv
// Shared definitions for the two-port single-port-RAM arbiter: FSM encoding,
// port count and port identifiers.
package spram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam int NUM_PORTS = 2;

    localparam logic P0 = 1'b0;
    localparam logic P1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-input grant generator. Round-robin on a preferred-port pointer, or plain
// port-0-first priority when SPRAM_ARB_FIXED_PRIO_EN is defined (no pointer).
module rr_arb2
    import spram_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
`ifndef SPRAM_ARB_FIXED_PRIO_EN
    input  logic                 ptr,
`endif
    output logic [NUM_PORTS-1:0] gnt
);

    always_comb begin
        // NOTE: default assignment first so no path through the block infers a latch.
        gnt = '0;
`ifdef SPRAM_ARB_FIXED_PRIO_EN
        if (req[P0]) begin
            gnt[P0] = 1'b1;
        end else if (req[P1]) begin
            gnt[P1] = 1'b1;
        end
`else
        case (req)
            2'b01:   gnt[P0] = 1'b1;
            2'b10:   gnt[P1] = 1'b1;
            2'b11:   gnt[ptr] = 1'b1;
            default: gnt = '0;
        endcase
`endif
    end

endmodule

// File: rtl/spram_arbiter.sv
// Arbitrates two requesters onto one external single-port RAM with a fixed
// IDLE -> ISSUE -> RESP sequence. Optional macro: SPRAM_ARB_FIXED_PRIO_EN.
module spram_arbiter
    import spram_arb_pkg::*;
#(
    parameter  int REG_WIDTH = 64,
    parameter  int REG_DEPTH = 64,
    localparam int ADDR_W    = $clog2(REG_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 p0_valid,
    input  logic                 p1_valid,
    output logic                 p0_ready,
    output logic                 p1_ready,
    input  logic                 p0_we,
    input  logic                 p1_we,
    input  logic [ADDR_W-1:0]    p0_addr,
    input  logic [ADDR_W-1:0]    p1_addr,
    input  logic [REG_WIDTH-1:0] p0_wdata,
    input  logic [REG_WIDTH-1:0] p1_wdata,
    output logic                 p0_resp,
    output logic                 p1_resp,
    output logic [REG_WIDTH-1:0] p0_rdata,
    output logic [REG_WIDTH-1:0] p1_rdata,
    output logic                 ram_cs_n,
    output logic                 ram_we,
    output logic [ADDR_W-1:0]    ram_addr,
    output logic [REG_WIDTH-1:0] ram_din,
    input  logic [REG_WIDTH-1:0] ram_dout
);

    state_t                 state;
    state_t                 state_next;
    logic [NUM_PORTS-1:0]   gnt;
    logic                   handshake;
    logic                   cap_id;
    logic                   cap_we;
    logic [ADDR_W-1:0]      cap_addr;
    logic [REG_WIDTH-1:0]   cap_wdata;

`ifdef SPRAM_ARB_FIXED_PRIO_EN
    rr_arb2 u_arb (
        .req ({p1_valid, p0_valid}),
        .gnt (gnt)
    );
`else
    logic ptr;

    rr_arb2 u_arb (
        .req ({p1_valid, p0_valid}),
        .ptr (ptr),
        .gnt (gnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= P0;
        end else if (handshake) begin
            ptr <= gnt[P1] ? P0 : P1;
        end
    end
`endif

    assign handshake = p0_ready | p1_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: non-blocking for all sequential state so every flop samples pre-edge values.
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (handshake) state_next = ISSUE;
            ISSUE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Requester inputs are only looked at on the handshake edge; the RAM
    // command and response are driven from these registers afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_id    <= P0;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
        end else if (handshake) begin
            cap_id    <= gnt[P1] ? P1 : P0;
            cap_we    <= gnt[P1] ? p1_we    : p0_we;
            cap_addr  <= gnt[P1] ? p1_addr  : p0_addr;
            cap_wdata <= gnt[P1] ? p1_wdata : p0_wdata;
        end
    end

    always_comb begin
        p0_ready = 1'b0;
        p1_ready = 1'b0;
        p0_resp  = 1'b0;
        p1_resp  = 1'b0;
        p0_rdata = '0;
        p1_rdata = '0;
        ram_cs_n = 1'b1;
        ram_we   = 1'b0;
        ram_addr = cap_addr;
        ram_din  = cap_wdata;
        case (state)
            IDLE: begin
                // NOTE: state already sits in IDLE during reset, so ready must also see rst_n.
                p0_ready = rst_n & gnt[P0];
                p1_ready = rst_n & gnt[P1];
            end
            ISSUE: begin
                ram_cs_n = 1'b0;
                ram_we   = cap_we;
            end
            RESP: begin
                if (cap_id == P0) begin
                    p0_resp  = 1'b1;
                    p0_rdata = cap_we ? '0 : ram_dout;
                end else begin
                    p1_resp  = 1'b1;
                    p1_rdata = cap_we ? '0 : ram_dout;
                end
            end
            default: ;
        endcase
    end

endmodule
